// File: rtl/branch_pkg.sv
// Shared types for the branch reservation station: branch encodings, RS entry and issue-stage records.
package branch_pkg;

   localparam int BR_TAG_W = 4;

   typedef enum logic [2:0] {
      BR_BEQ  = 3'b000,
      BR_BNE  = 3'b001,
      BR_BLT  = 3'b100,
      BR_BGE  = 3'b101,
      BR_BLTU = 3'b110,
      BR_JAL  = 3'b111
   } br_type_e;

   typedef struct packed {
      logic                valid;
      logic [BR_TAG_W-1:0] rob_tag;
      logic [31:0]         pc;
      logic [31:0]         imm;
      br_type_e            br_type;
      logic                pred_tk;
      logic [31:0]         pred_tgt;
      logic                rs1_rdy;
      logic [BR_TAG_W-1:0] rs1_tag;
      logic [31:0]         rs1_val;
      logic                rs2_rdy;
      logic [BR_TAG_W-1:0] rs2_tag;
      logic [31:0]         rs2_val;
   } brs_entry_t;

   typedef struct packed {
      logic [BR_TAG_W-1:0] rob_tag;
      logic [31:0]         pc;
      logic [31:0]         imm;
      br_type_e            br_type;
      logic                pred_tk;
      logic [31:0]         pred_tgt;
      logic [31:0]         rs1;
      logic [31:0]         rs2;
   } brs_issue_t;

endpackage

// File: rtl/branch_unit.sv
// Combinational branch resolve: direction, actual next PC and mispredict flag; no latency, no backpressure.
module branch_unit
   import branch_pkg::*;
(
   input  br_type_e    br_type,
   input  logic [31:0] pc,
   input  logic [31:0] imm,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic        pred_tk,
   input  logic [31:0] pred_tgt,
   output logic        taken,
   output logic        mispredict,
   output logic [31:0] correct_pc
);

   always_comb begin
      taken = 1'b0;
      case (br_type)
         BR_BEQ:  taken = (rs1 == rs2);
         BR_BNE:  taken = (rs1 != rs2);
         BR_BLT:  taken = ($signed(rs1) < $signed(rs2));
         BR_BGE:  taken = ($signed(rs1) >= $signed(rs2));
         BR_BLTU: taken = (rs1 < rs2);
         BR_JAL:  taken = 1'b1;
         default: taken = 1'b0;
      endcase
      correct_pc = taken ? (pc + imm) : (pc + 32'd4);
      mispredict = (taken != pred_tk) || (correct_pc != pred_tgt);
   end

endmodule

// File: rtl/branch_rs_ctrl.sv
// Branch RS + issue: oldest-ready select, result 2 cycles after eligibility, alloc_ready from registered occupancy.
// Optional BRANCH_STATS_EN adds saturating resolved/mispredict counters; otherwise stat_* read 0.
module branch_rs_ctrl
   import branch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = BR_TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_valid,
   output logic             alloc_ready,
   input  logic [TAG_W-1:0] alloc_rob_tag,
   input  logic [31:0]      alloc_pc,
   input  logic [31:0]      alloc_imm,
   input  logic [2:0]       alloc_type,
   input  logic             alloc_pred_tk,
   input  logic [31:0]      alloc_pred_tgt,
   input  logic             alloc_rs1_rdy,
   input  logic [TAG_W-1:0] alloc_rs1_tag,
   input  logic [31:0]      alloc_rs1_val,
   input  logic             alloc_rs2_rdy,
   input  logic [TAG_W-1:0] alloc_rs2_tag,
   input  logic [31:0]      alloc_rs2_val,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_value,
   input  logic             flush,
   output logic             res_valid,
   output logic [TAG_W-1:0] res_rob_tag,
   output logic             res_taken,
   output logic             res_mispredict,
   output logic [31:0]      res_correct_pc,
   output logic [31:0]      stat_branches,
   output logic [31:0]      stat_mispred
);

   localparam int IDX_W = $clog2(DEPTH);

   brs_entry_t       ent_q [DEPTH];
   // age_q[i][j] set means entry j is older than entry i
   logic [DEPTH-1:0] age_q [DEPTH];
   logic [DEPTH-1:0] vld_vec, rdy_vec, sel_oh;
   logic [IDX_W-1:0] alloc_idx, sel_idx;
   logic             sel_vld, alloc_fire;
   brs_entry_t       new_ent;
   brs_issue_t       s1_q;
   logic             s1_vld;
   logic             bu_taken, bu_mispredict;
   logic [31:0]      bu_correct_pc;

   always_comb begin
      vld_vec = '0;
      rdy_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         vld_vec[i] = ent_q[i].valid;
         rdy_vec[i] = ent_q[i].valid & ent_q[i].rs1_rdy & ent_q[i].rs2_rdy;
      end
   end

   always_comb begin
      alloc_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!vld_vec[i]) alloc_idx = IDX_W'(i);
      end
   end

   assign alloc_ready = ~(&vld_vec);
   assign alloc_fire  = alloc_valid & alloc_ready & ~flush;

   // Operands arriving on the CDB in the dispatch cycle are captured directly.
   always_comb begin
      new_ent          = '0;
      new_ent.valid    = 1'b1;
      new_ent.rob_tag  = alloc_rob_tag;
      new_ent.pc       = alloc_pc;
      new_ent.imm      = alloc_imm;
      new_ent.br_type  = br_type_e'(alloc_type);
      new_ent.pred_tk  = alloc_pred_tk;
      new_ent.pred_tgt = alloc_pred_tgt;
      new_ent.rs1_rdy  = alloc_rs1_rdy;
      new_ent.rs1_tag  = alloc_rs1_tag;
      new_ent.rs1_val  = alloc_rs1_val;
      new_ent.rs2_rdy  = alloc_rs2_rdy;
      new_ent.rs2_tag  = alloc_rs2_tag;
      new_ent.rs2_val  = alloc_rs2_val;
      if (!alloc_rs1_rdy && cdb_valid && (cdb_tag == alloc_rs1_tag)) begin
         new_ent.rs1_rdy = 1'b1;
         new_ent.rs1_val = cdb_value;
      end
      if (!alloc_rs2_rdy && cdb_valid && (cdb_tag == alloc_rs2_tag)) begin
         new_ent.rs2_rdy = 1'b1;
         new_ent.rs2_val = cdb_value;
      end
   end

   always_comb begin
      sel_oh  = '0;
      sel_idx = '0;
      sel_vld = |rdy_vec;
      for (int i = 0; i < DEPTH; i++) begin
         sel_oh[i] = rdy_vec[i] & ~(|(age_q[i] & rdy_vec));
         if (sel_oh[i]) sel_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
            age_q[i] <= '0;
         end
         s1_vld         <= 1'b0;
         s1_q           <= '0;
         res_valid      <= 1'b0;
         res_rob_tag    <= '0;
         res_taken      <= 1'b0;
         res_mispredict <= 1'b0;
         res_correct_pc <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
         s1_vld    <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid) begin
               if (cdb_valid && !ent_q[i].rs1_rdy && (ent_q[i].rs1_tag == cdb_tag)) begin
                  ent_q[i].rs1_rdy <= 1'b1;
                  ent_q[i].rs1_val <= cdb_value;
               end
               if (cdb_valid && !ent_q[i].rs2_rdy && (ent_q[i].rs2_tag == cdb_tag)) begin
                  ent_q[i].rs2_rdy <= 1'b1;
                  ent_q[i].rs2_val <= cdb_value;
               end
               if (sel_oh[i]) ent_q[i].valid <= 1'b0;
            end
         end
         if (alloc_fire) begin
            ent_q[alloc_idx] <= new_ent;
            age_q[alloc_idx] <= vld_vec;
            for (int j = 0; j < DEPTH; j++) age_q[j][alloc_idx] <= 1'b0;
         end
         s1_vld <= sel_vld;
         if (sel_vld) begin
            s1_q.rob_tag  <= ent_q[sel_idx].rob_tag;
            s1_q.pc       <= ent_q[sel_idx].pc;
            s1_q.imm      <= ent_q[sel_idx].imm;
            s1_q.br_type  <= ent_q[sel_idx].br_type;
            s1_q.pred_tk  <= ent_q[sel_idx].pred_tk;
            s1_q.pred_tgt <= ent_q[sel_idx].pred_tgt;
            s1_q.rs1      <= ent_q[sel_idx].rs1_val;
            s1_q.rs2      <= ent_q[sel_idx].rs2_val;
         end
         res_valid <= s1_vld;
         if (s1_vld) begin
            res_rob_tag    <= s1_q.rob_tag;
            res_taken      <= bu_taken;
            res_mispredict <= bu_mispredict;
            res_correct_pc <= bu_correct_pc;
         end
      end
   end

   branch_unit u_branch_unit (
      .br_type    (s1_q.br_type),
      .pc         (s1_q.pc),
      .imm        (s1_q.imm),
      .rs1        (s1_q.rs1),
      .rs2        (s1_q.rs2),
      .pred_tk    (s1_q.pred_tk),
      .pred_tgt   (s1_q.pred_tgt),
      .taken      (bu_taken),
      .mispredict (bu_mispredict),
      .correct_pc (bu_correct_pc)
   );

`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches_q, stat_mispred_q;

   // Counters survive flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches_q <= '0;
         stat_mispred_q  <= '0;
      end else if (res_valid) begin
         if (stat_branches_q != '1) stat_branches_q <= stat_branches_q + 32'd1;
         if (res_mispredict && (stat_mispred_q != '1)) stat_mispred_q <= stat_mispred_q + 32'd1;
      end
   end

   assign stat_branches = stat_branches_q;
   assign stat_mispred  = stat_mispred_q;
`else
   assign stat_branches = '0;
   assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_rs_ctrl.sv
// Directed bench for branch_rs_ctrl with hand-computed expectations for issue order, bypass, flush and wrap.
module tb_branch_rs_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        alloc_valid, alloc_ready;
   logic [3:0]  alloc_rob_tag;
   logic [31:0] alloc_pc, alloc_imm;
   logic [2:0]  alloc_type;
   logic        alloc_pred_tk;
   logic [31:0] alloc_pred_tgt;
   logic        alloc_rs1_rdy, alloc_rs2_rdy;
   logic [3:0]  alloc_rs1_tag, alloc_rs2_tag;
   logic [31:0] alloc_rs1_val, alloc_rs2_val;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic        flush;
   logic        res_valid, res_taken, res_mispredict;
   logic [3:0]  res_rob_tag;
   logic [31:0] res_correct_pc, stat_branches, stat_mispred;

   int checks = 0;
   int errors = 0;

   branch_rs_ctrl #(.DEPTH(4), .TAG_W(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .alloc_valid    (alloc_valid),
      .alloc_ready    (alloc_ready),
      .alloc_rob_tag  (alloc_rob_tag),
      .alloc_pc       (alloc_pc),
      .alloc_imm      (alloc_imm),
      .alloc_type     (alloc_type),
      .alloc_pred_tk  (alloc_pred_tk),
      .alloc_pred_tgt (alloc_pred_tgt),
      .alloc_rs1_rdy  (alloc_rs1_rdy),
      .alloc_rs1_tag  (alloc_rs1_tag),
      .alloc_rs1_val  (alloc_rs1_val),
      .alloc_rs2_rdy  (alloc_rs2_rdy),
      .alloc_rs2_tag  (alloc_rs2_tag),
      .alloc_rs2_val  (alloc_rs2_val),
      .cdb_valid      (cdb_valid),
      .cdb_tag        (cdb_tag),
      .cdb_value      (cdb_value),
      .flush          (flush),
      .res_valid      (res_valid),
      .res_rob_tag    (res_rob_tag),
      .res_taken      (res_taken),
      .res_mispredict (res_mispredict),
      .res_correct_pc (res_correct_pc),
      .stat_branches  (stat_branches),
      .stat_mispred   (stat_mispred)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alloc(input logic [3:0] tag, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [2:0] typ, input logic ptk, input logic [31:0] ptgt,
                        input logic r1rdy, input logic [3:0] r1tag, input logic [31:0] r1val,
                        input logic r2rdy, input logic [3:0] r2tag, input logic [31:0] r2val);
      alloc_valid    = 1'b1;
      alloc_rob_tag  = tag;
      alloc_pc       = pc;
      alloc_imm      = imm;
      alloc_type     = typ;
      alloc_pred_tk  = ptk;
      alloc_pred_tgt = ptgt;
      alloc_rs1_rdy  = r1rdy;
      alloc_rs1_tag  = r1tag;
      alloc_rs1_val  = r1val;
      alloc_rs2_rdy  = r2rdy;
      alloc_rs2_tag  = r2tag;
      alloc_rs2_val  = r2val;
   endtask

   task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
      cdb_valid = 1'b1;
      cdb_tag   = tag;
      cdb_value = val;
   endtask

   task automatic expect_res(input string tag, input logic [3:0] rtag, input logic tk,
                             input logic mp, input logic [31:0] pc);
      chk({tag, "_vld"}, res_valid, 1);
      chk({tag, "_tag"}, res_rob_tag, rtag);
      chk({tag, "_tk"}, res_taken, tk);
      chk({tag, "_mp"}, res_mispredict, mp);
      chk({tag, "_pc"}, res_correct_pc, pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; cdb_valid = 1'b0;
      cdb_tag = '0; cdb_value = '0;
      alloc(4'd0, 32'd0, 32'd0, 3'b000, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      alloc_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_ready", alloc_ready, 1);
      chk("rst_res_vld", res_valid, 0);
      chk("rst_res_pc", res_correct_pc, 0);
      chk("rst_stat_br", stat_branches, 0);
      chk("rst_stat_mp", stat_mispred, 0);
      tick();
      chk("rst_ready_c1", alloc_ready, 1);

      // BEQ equal operands, predicted not-taken
      alloc(4'd3, 32'h100, 32'h20, 3'b000, 1'b0, 32'h104, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd5);
      tick(); alloc_valid = 1'b0;
      chk("t1_lat1", res_valid, 0);
      tick();
      chk("t1_lat2", res_valid, 0);
      tick();
      expect_res("t1", 4'd3, 1'b1, 1'b1, 32'h120);
      tick();
      chk("t1_pulse", res_valid, 0);

      // BLT waiting on tag 7, woken by -1
      alloc(4'd1, 32'h200, 32'h40, 3'b100, 1'b0, 32'h204, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd0);
      tick(); alloc_valid = 1'b0;
      tick(); tick();
      chk("t2_wait", res_valid, 0);
      cdb(4'd7, 32'hFFFF_FFFF);
      tick(); cdb_valid = 1'b0;
      tick();
      chk("t2_cdb2", res_valid, 0);
      tick();
      expect_res("t2", 4'd1, 1'b1, 1'b1, 32'h240);

      // Fill all four entries; 0 and 2 wait on tag 12, 1 and 3 on tag 13
      for (int k = 0; k < 4; k++) begin
         alloc(4'(8 + k), 32'h400 + 32'(16 * k), 32'h40, 3'b000, 1'b1, 32'h440 + 32'(16 * k),
               1'b0, (k % 2 == 0) ? 4'd12 : 4'd13, 32'd0, 1'b1, 4'd0, 32'h12);
         chk("t3_fill_rdy", alloc_ready, 1);
         tick();
      end
      chk("t3_full", alloc_ready, 0);
      alloc(4'd15, 32'h480, 32'h40, 3'b000, 1'b1, 32'h4C0, 1'b1, 4'd0, 32'h12, 1'b1, 4'd0, 32'h12);
      tick(); alloc_valid = 1'b0;
      chk("t3_full_hold", alloc_ready, 0);
      cdb(4'd12, 32'h12);
      tick(); cdb_valid = 1'b0;
      chk("t3_full_wake", alloc_ready, 0);
      tick();
      chk("t3_ready_after_issue", alloc_ready, 1);
      tick();
      expect_res("t3_a", 4'd8, 1'b1, 1'b0, 32'h440);
      tick();
      expect_res("t3_b", 4'd10, 1'b1, 1'b0, 32'h460);
      tick();
      chk("t3_idle", res_valid, 0);
      // Youngest lands in entry 0 but must issue after entries 1 and 3
      alloc(4'd4, 32'h500, 32'h40, 3'b000, 1'b1, 32'h540, 1'b0, 4'd13, 32'd0, 1'b1, 4'd0, 32'h12);
      tick(); alloc_valid = 1'b0;
      cdb(4'd13, 32'h12);
      tick(); cdb_valid = 1'b0;
      tick();
      chk("t3_age_lat", res_valid, 0);
      tick();
      expect_res("t3_c", 4'd9, 1'b1, 1'b0, 32'h450);
      tick();
      expect_res("t3_d", 4'd11, 1'b1, 1'b0, 32'h470);
      tick();
      expect_res("t3_e", 4'd4, 1'b1, 1'b0, 32'h540);
      tick();
      chk("t3_drained", res_valid, 0);
      chk("t3_drained_rdy", alloc_ready, 1);

      // BNE with rs2 bypassed from the CDB in the alloc cycle
      alloc(4'd2, 32'h300, 32'h80, 3'b001, 1'b1, 32'h380, 1'b1, 4'd0, 32'h10, 1'b0, 4'd5, 32'd0);
      cdb(4'd5, 32'h10);
      tick(); alloc_valid = 1'b0; cdb_valid = 1'b0;
      tick();
      chk("t4_lat", res_valid, 0);
      tick();
      expect_res("t4", 4'd2, 1'b0, 1'b1, 32'h304);

      // Flush while A is in S1 and B waits on tag 9; alloc and CDB in the flush cycle are dropped
      alloc(4'd6, 32'h600, 32'h10, 3'b000, 1'b1, 32'h610, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
      tick();
      alloc(4'd7, 32'h700, 32'h10, 3'b000, 1'b1, 32'h710, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd0);
      tick();
      alloc(4'd12, 32'h800, 32'h10, 3'b000, 1'b1, 32'h810, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
      cdb(4'd9, 32'd0);
      flush = 1'b1;
      tick(); flush = 1'b0; alloc_valid = 1'b0; cdb_valid = 1'b0;
      chk("t5_res_vld", res_valid, 0);
      chk("t5_ready", alloc_ready, 1);
      chk("t5_hold_pc", res_correct_pc, 32'h304);
      chk("t5_hold_tag", res_rob_tag, 2);
      cdb(4'd9, 32'd0);
      tick(); cdb_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("t5_quiet", res_valid, 0);
         tick();
      end

      // JAL across the 2^32 wrap
      alloc(4'd1, 32'hFFFF_FFF0, 32'h20, 3'b111, 1'b1, 32'h10, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
      tick(); alloc_valid = 1'b0;
      tick(); tick();
      expect_res("t6", 4'd1, 1'b1, 1'b0, 32'h10);
`ifdef BRANCH_STATS_EN
      chk("t6_stat_br_pre", stat_branches, 8);
      tick();
      chk("t6_stat_br", stat_branches, 9);
      chk("t6_stat_mp", stat_mispred, 3);
`else
      tick();
      chk("t6_stat_br", stat_branches, 0);
      chk("t6_stat_mp", stat_mispred, 0);
`endif

      // Reset while a branch sits in S1
      alloc(4'd5, 32'h900, 32'h8, 3'b000, 1'b1, 32'h908, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 32'd2);
      tick(); alloc_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick(); rst = 1'b0;
      chk("t7_res_vld", res_valid, 0);
      chk("t7_res_pc", res_correct_pc, 0);
      chk("t7_ready", alloc_ready, 1);
      chk("t7_stat_br", stat_branches, 0);
      tick();
      chk("t7_quiet", res_valid, 0);
      tick();
      chk("t7_quiet2", res_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
